blockxfer_seq: RTL and testbench

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It accepts a decoded block-transfer instruction and its base register value from Decode, then issues one memory beat per listed register, in ascending register order at ascending addresses. It computes and emits base writeback and stalls Decode while busy. It sits between Decode and the memory/writeback stage.

---
 rtl/blockxfer_seq_pkg.sv | 21 ++
 rtl/blockxfer_seq_popcount16.sv | 14 +
 rtl/blockxfer_seq.sv | 191 +++++++++++++++++++
 tb/tb_blockxfer_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockxfer_seq_pkg.sv
// Shared constants for the block-transfer sequencer: instruction field positions and FSM states.
// Extends the ARM constant set with the LDM/STM bit layout.
package blockxfer_seq_pkg;

    localparam int unsigned BDT_P = 24;
    localparam int unsigned BDT_U = 23;
    localparam int unsigned BDT_S = 22;
    localparam int unsigned BDT_W = 21;
    localparam int unsigned BDT_L = 20;

    localparam int unsigned BDT_RN_MSB = 19;
    localparam int unsigned BDT_RN_LSB = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StWb   = 2'd2,
        StDone = 2'd3
    } bxfer_state_e;

endpackage

// File: rtl/blockxfer_seq_popcount16.sv
// Population count of a 16-bit register list, yielding 0..16.
module blockxfer_seq_popcount16 (
    input  logic [15:0] bits,
    output logic [4:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'd0, bits[i]};
        end
    end

endmodule

// File: rtl/blockxfer_seq.sv
// LDM/STM sequencer: accepts a decoded block transfer, issues one beat per listed register in
// ascending order at ascending addresses, then emits base writeback and a retire pulse.
module blockxfer_seq
    import blockxfer_seq_pkg::*;
#(
    parameter int unsigned FORCE_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] insn,
    input  logic [31:0] base,
    output logic        stall,

    output logic        xfer_valid,
    input  logic        xfer_ready,
    output logic [3:0]  xfer_reg,
    output logic [31:0] xfer_addr,
    output logic        xfer_load,
    output logic        xfer_user,
    output logic        xfer_pc,
    output logic        xfer_last,

    output logic        wb_valid,
    output logic [3:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        done
);

    localparam logic [31:0] AddrMask = (FORCE_ALIGN != 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;

    bxfer_state_e state_q, state_d;

    logic [15:0] mask_q;
    logic [31:0] addr_q;
    logic [31:0] final_q;
    logic [3:0]  rn_q;
    logic        load_q;
    logic        user_q;
    logic        wback_q;
    logic        rn_in_list_q;

    logic [15:0] list;
    logic [3:0]  rn;
    logic [4:0]  n;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [31:0] final_base;
    logic        accept;
    logic        beat;
    logic [3:0]  cur_reg;
    logic        last_beat;

    logic        unused_insn;
    assign unused_insn = ^insn[31:25];

    assign list = insn[15:0];
    assign rn   = insn[BDT_RN_MSB:BDT_RN_LSB];

    blockxfer_seq_popcount16 u_popcount (
        .bits  (list),
        .count (n)
    );

    assign span = {25'd0, n, 2'b00};

    always_comb begin
        unique case ({insn[BDT_P], insn[BDT_U]})
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + 32'd4;
            2'b00:   start_addr = base - span + 32'd4;
            default: start_addr = base - span;
        endcase
        final_base = insn[BDT_U] ? (base + span) : (base - span);
    end

    assign accept = (state_q == StIdle) && start_valid;
    assign beat   = (state_q == StXfer) && xfer_ready;

    // Lowest set bit of the remaining mask selects the register for the current beat.
    always_comb begin
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_reg = 4'(i);
            end
        end
    end

    assign last_beat = (mask_q != 16'd0) && ((mask_q & (mask_q - 16'd1)) == 16'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    if (n != 5'd0) begin
                        state_d = StXfer;
                    end else if (insn[BDT_W]) begin
                        state_d = StWb;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StXfer: begin
                if (xfer_ready && last_beat) begin
                    state_d = wback_q ? StWb : StDone;
                end
            end
            StWb:    state_d = StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= '0;
            addr_q       <= '0;
            final_q      <= '0;
            rn_q         <= '0;
            load_q       <= 1'b0;
            user_q       <= 1'b0;
            wback_q      <= 1'b0;
            rn_in_list_q <= 1'b0;
        end else if (accept) begin
            mask_q       <= list;
            addr_q       <= start_addr;
            final_q      <= final_base;
            rn_q         <= rn;
            load_q       <= insn[BDT_L];
            user_q       <= insn[BDT_S];
            wback_q      <= insn[BDT_W];
            // A loaded Rn overrides the writeback value.
            rn_in_list_q <= insn[BDT_L] && list[rn];
        end else if (beat) begin
            mask_q <= mask_q & ~(16'd1 << cur_reg);
            addr_q <= addr_q + 32'd4;
        end
    end

    // Output logic
    always_comb begin
        start_ready = (state_q == StIdle);
        stall       = (state_q != StIdle);
        xfer_valid  = 1'b0;
        xfer_reg    = '0;
        xfer_addr   = '0;
        xfer_load   = load_q;
        xfer_user   = user_q;
        xfer_pc     = 1'b0;
        xfer_last   = 1'b0;
        wb_valid    = 1'b0;
        wb_reg      = '0;
        wb_data     = '0;
        done        = 1'b0;
        unique case (state_q)
            StXfer: begin
                xfer_valid = 1'b1;
                xfer_reg   = cur_reg;
                xfer_addr  = addr_q & AddrMask;
                xfer_last  = last_beat;
                xfer_pc    = load_q && (cur_reg == 4'd15);
            end
            StWb: begin
                wb_valid = !rn_in_list_q;
                wb_reg   = rn_q;
                wb_data  = final_q;
                done     = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_blockxfer_seq.sv
// Self-checking bench for blockxfer_seq: queue-based model of expected beats and writeback,
// directed cases with literal expectations, then randomized instructions and memory backpressure.
module tb_blockxfer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] insn;
    logic [31:0] base;
    logic        stall;
    logic        xfer_valid;
    logic        xfer_ready;
    logic [3:0]  xfer_reg;
    logic [31:0] xfer_addr;
    logic        xfer_load;
    logic        xfer_user;
    logic        xfer_pc;
    logic        xfer_last;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        done;

    always #5 clk = ~clk;

    blockxfer_seq #(.FORCE_ALIGN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .insn        (insn),
        .base        (base),
        .stall       (stall),
        .xfer_valid  (xfer_valid),
        .xfer_ready  (xfer_ready),
        .xfer_reg    (xfer_reg),
        .xfer_addr   (xfer_addr),
        .xfer_load   (xfer_load),
        .xfer_user   (xfer_user),
        .xfer_pc     (xfer_pc),
        .xfer_last   (xfer_last),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .done        (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: expected beats still to be issued and the writeback outcome.
    logic [3:0]  q_reg[$];
    logic [31:0] q_addr[$];
    logic        exp_load, exp_user, exp_wbv;
    logic [3:0]  exp_rn;
    logic [31:0] exp_wbd;
    bit          pending = 1'b0;

    // Observed log of accepted beats and writebacks for the current instruction.
    logic [3:0]  got_reg[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_wbd;
    int          got_wb_cnt;
    int          stall_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input bit p, input bit u, input bit s, input bit w,
                                       input bit l, input logic [3:0] rn,
                                       input logic [15:0] lst);
        return {7'b1110100, p, u, s, w, l, rn, lst};
    endfunction

    task automatic model(input logic [31:0] i, input logic [31:0] b);
        logic [15:0] lst;
        int          n;
        int          k;
        logic [31:0] four_n;
        logic [31:0] start;
        lst    = i[15:0];
        n      = $countones(lst);
        four_n = 32'(4 * n);
        case ({i[24], i[23]})
            2'b01:   start = b;
            2'b11:   start = b + 32'd4;
            2'b00:   start = b - four_n + 32'd4;
            default: start = b - four_n;
        endcase
        q_reg.delete();
        q_addr.delete();
        got_reg.delete();
        got_addr.delete();
        got_wbd    = '0;
        got_wb_cnt = 0;
        stall_cnt  = 0;
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (lst[r]) begin
                q_reg.push_back(4'(r));
                q_addr.push_back((start + 32'(4 * k)) & 32'hFFFF_FFFC);
                k++;
            end
        end
        exp_load = i[20];
        exp_user = i[22];
        exp_rn   = i[19:16];
        exp_wbv  = i[21] && !(i[20] && lst[i[19:16]]);
        exp_wbd  = i[23] ? (b + four_n) : (b - four_n);
        pending  = 1'b1;
    endtask

    // Compare process: every cycle, outputs are checked against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("stall_vs_ready", stall, !start_ready);
            if (xfer_valid) begin
                chk("beat_expected", 32'(q_reg.size() != 0), 1);
                if (q_reg.size() != 0) begin
                    chk("xfer_reg", xfer_reg, q_reg[0]);
                    chk("xfer_addr", xfer_addr, q_addr[0]);
                    chk("xfer_last", xfer_last, q_reg.size() == 1);
                    chk("xfer_pc", xfer_pc, exp_load && (q_reg[0] == 4'd15));
                    chk("xfer_load", xfer_load, exp_load);
                    chk("xfer_user", xfer_user, exp_user);
                    if (xfer_ready) begin
                        got_reg.push_back(xfer_reg);
                        got_addr.push_back(xfer_addr);
                        void'(q_reg.pop_front());
                        void'(q_addr.pop_front());
                    end else begin
                        stall_cnt++;
                    end
                end
            end else if (!pending) begin
                chk("idle_no_beat", xfer_valid, 0);
            end
            if (done) begin
                chk("done_pending", 32'(pending), 1);
                chk("done_beats_left", 32'(q_reg.size()), 0);
                chk("ready_low_on_done", start_ready, 0);
                chk("wb_valid", wb_valid, exp_wbv);
                if (wb_valid) begin
                    chk("wb_reg", wb_reg, exp_rn);
                    chk("wb_data", wb_data, exp_wbd);
                    got_wbd = wb_data;
                    got_wb_cnt++;
                end
                pending = 1'b0;
            end else begin
                chk("wb_without_done", wb_valid, 0);
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("start_ready_wait", start_ready, 1);
        model(i, b);
        @(posedge clk);
        #1;
        start_valid = 1'b1;
        insn        = i;
        base        = b;
        xfer_ready  = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        insn        = $urandom;
        base        = $urandom;
    endtask

    task automatic finish_insn(input int ready_pct, input int hold, input int exp_n);
        int c;
        bit seen;
        c    = 0;
        seen = 1'b0;
        while (c < 300) begin
            xfer_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
            if (hold > 0) hold--;
            @(negedge clk);
            c++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(seen), 1);
        if (exp_n == 0) chk("empty_done_latency", 32'(c), 1);
        chk("beat_count", 32'(got_reg.size()), 32'(exp_n));
        @(posedge clk);
        #1;
        xfer_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_done", start_ready, 1);
        if (!seen) begin
            pending = 1'b0;
            q_reg.delete();
            q_addr.delete();
        end
    endtask

    task automatic run_insn(input logic [31:0] i, input logic [31:0] b, input int ready_pct,
                            input int hold);
        issue(i, b);
        finish_insn(ready_pct, hold, $countones(i[15:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        insn        = '0;
        base        = '0;
        xfer_ready  = 1'b0;
        #2;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_xfer_valid", xfer_valid, 0);
        chk("rst_xfer_addr", xfer_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LDMIA r0!,{r1,r2,r4}
        run_insn(mk(0, 1, 0, 1, 1, 4'd0, 16'h0016), 32'h0000_1000, 100, 0);
        chk("t1_n", 32'(got_reg.size()), 3);
        chk("t1_r0", got_reg[0], 1);
        chk("t1_r1", got_reg[1], 2);
        chk("t1_r2", got_reg[2], 4);
        chk("t1_a0", got_addr[0], 32'h1000);
        chk("t1_a2", got_addr[2], 32'h1008);
        chk("t1_wb", got_wbd, 32'h100C);

        // STMDB r13!,{r4-r7,r14}
        run_insn(mk(1, 0, 0, 1, 0, 4'd13, 16'h40F0), 32'h0000_2000, 100, 0);
        chk("t2_n", 32'(got_reg.size()), 5);
        chk("t2_r4", got_reg[4], 14);
        chk("t2_a0", got_addr[0], 32'h1FEC);
        chk("t2_a4", got_addr[4], 32'h1FFC);
        chk("t2_wb", got_wbd, 32'h1FEC);

        // LDMIB r2,{r15} with wrap and three stalled cycles
        run_insn(mk(1, 1, 0, 0, 1, 4'd2, 16'h8000), 32'hFFFF_FFFC, 100, 3);
        chk("t3_reg", got_reg[0], 15);
        chk("t3_addr", got_addr[0], 32'h0000_0000);
        chk("t3_stalls", 32'(stall_cnt), 3);
        chk("t3_no_wb", 32'(got_wb_cnt), 0);

        // LDMDA r3!,{r0,r3}: loaded Rn suppresses writeback
        run_insn(mk(0, 0, 0, 1, 1, 4'd3, 16'h0009), 32'h0000_0100, 100, 0);
        chk("t4_a0", got_addr[0], 32'h0000_00FC);
        chk("t4_a1", got_addr[1], 32'h0000_0100);
        chk("t4_no_wb", 32'(got_wb_cnt), 0);

        // Empty list with writeback
        run_insn(mk(0, 1, 0, 1, 0, 4'd5, 16'h0000), 32'h0000_0040, 100, 0);
        chk("t5_wb_cnt", 32'(got_wb_cnt), 1);
        chk("t5_wb", got_wbd, 32'h40);

        // Reset during beat 2 of a 5-register STM
        issue(mk(0, 1, 0, 1, 0, 4'd1, 16'h01F0), 32'h0000_3000);
        xfer_ready = 1'b1;
        for (int g = 0; g < 20 && got_reg.size() < 1; g++) @(negedge clk);
        @(posedge clk);
        #1;
        xfer_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_xfer_valid", xfer_valid, 0);
        chk("abort_xfer_addr", xfer_addr, 0);
        chk("abort_xfer_reg", xfer_reg, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_wb", wb_valid, 0);
        pending = 1'b0;
        q_reg.delete();
        q_addr.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_hold_done", done, 0);
            chk("abort_hold_xfer", xfer_valid, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_insn(mk(0, 1, 0, 1, 1, 4'd0, 16'h0016), 32'h0000_1000, 100, 0);
        chk("t6_wb", got_wbd, 32'h100C);
        chk("t6_a1", got_addr[1], 32'h1004);

        // Randomized instructions with random backpressure
        for (int t = 0; t < 60; t++) begin
            logic [15:0] lst;
            logic [31:0] b;
            int          pct;
            case ($urandom_range(0, 3))
                0:       lst = 16'h0000;
                1:       lst = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: lst = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       pct = 100;
                1:       pct = 50;
                default: pct = 20;
            endcase
            run_insn(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        4'($urandom), lst), b, pct, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
